// File: rtl/bias_accum_7_pkg.sv
// Shared sizing constants and FSM state type for the layer-7 bias accumulator.
// Layer-7 kernel count and output size, coefficient width, accumulator format.
package bias_accum_7_pkg;

    // Layer-7 geometry from the shared layer sizes.
    localparam int KERN_S_K_7  = 16;
    localparam int OUT_S_7     = 8;
    localparam int OUT_PIX_7   = OUT_S_7 * OUT_S_7;
    localparam int COEFF_WIDTH = 16;

    // Accumulator format from the shared type definitions.
    localparam int ACC_WIDTH = 32;
    localparam int ACC_SHIFT = 8;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_sat_shift.sv
// Combinational bias add, arithmetic right shift and signed saturation.
// Optional fused ReLU when BIAS_ACCUM_RELU_EN is defined.
module bias_sat_shift #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [OUT_W-1:0] bias,
    output logic [OUT_W-1:0] res
);
    localparam int EXT_W = ACC_W + 1;

    logic signed [EXT_W-1:0] acc_x;
    logic signed [EXT_W-1:0] bias_x;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shifted;
    logic [EXT_W-OUT_W:0]    upper;
    logic [OUT_W-1:0]        sat;

    always_comb begin
        acc_x   = {acc[ACC_W-1], acc};
        bias_x  = {{(EXT_W-OUT_W){bias[OUT_W-1]}}, bias} << SHIFT;
        // One extra bit keeps the sum exact for any acc and bias.
        sum     = acc_x + bias_x;
        shifted = sum >>> SHIFT;
        // The value fits OUT_W bits when every bit from the sign down to OUT_W-1 agrees.
        upper   = shifted[EXT_W-1:OUT_W-1];
        if ((&upper) || (~|upper)) begin
            sat = shifted[OUT_W-1:0];
        end else if (shifted[EXT_W-1]) begin
            sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OUT_W-1){1'b1}}};
        end
        res = sat;
`ifdef BIAS_ACCUM_RELU_EN
        if (sat[OUT_W-1]) begin
            res = '0;
        end
`else
        res = sat;
`endif
    end

endmodule

// File: rtl/bias_accum_7.sv
// Layer-7 bias accumulator: loads N_CH bias words per frame, then biases, scales and
// saturates N_CH*N_PIX accumulators. Fused ReLU is enabled by macro BIAS_ACCUM_RELU_EN.
module bias_accum_7
    import bias_accum_7_pkg::*;
#(
    parameter int N_CH  = KERN_S_K_7,
    parameter int N_PIX = OUT_PIX_7,
    parameter int ACC_W = ACC_WIDTH,
    parameter int OUT_W = COEFF_WIDTH,
    parameter int SHIFT = ACC_SHIFT
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [OUT_W-1:0] bias_V_dout,
    input  logic             bias_V_empty_n,
    output logic             bias_V_read,
    input  logic [ACC_W-1:0] acc_V_dout,
    input  logic             acc_V_empty_n,
    output logic             acc_V_read,
    output logic [OUT_W-1:0] output_V_din,
    input  logic             output_V_full_n,
    output logic             output_V_write,
    output state_e           dbg_state
);
    // Handshake: a word moves across a FIFO port when read/write and empty_n/full_n
    // are both high at a rising edge; read strobes are combinational from empty_n,
    // and output_V_write/output_V_din come from a register held until full_n is seen.

    localparam int CH_W  = cnt_width(N_CH);
    localparam int PIX_W = cnt_width(N_PIX);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

    state_e           state;
    state_e           state_nxt;
    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic             out_valid;
    logic             last_popped;
    logic [OUT_W-1:0] out_data;
    logic [OUT_W-1:0] bank [N_CH];
    logic [OUT_W-1:0] res;

    logic bias_pop;
    logic acc_pop;
    logic out_take;
    logic ch_wrap;
    logic frame_end;

    assign out_take  = out_valid & output_V_full_n;
    assign ch_wrap   = (ch_cnt == CH_LAST);
    assign frame_end = ch_wrap & (pix_cnt == PIX_LAST);

    always_comb begin
        state_nxt = state;
        bias_pop  = 1'b0;
        acc_pop   = 1'b0;
        if (ap_rst_n) begin
            case (state)
                ST_LOAD: begin
                    bias_pop = bias_V_empty_n;
                    if (bias_pop && ch_wrap) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // After the last pop of the frame, only draining is allowed.
                    acc_pop = acc_V_empty_n & ~last_popped & (~out_valid | out_take);
                    if (out_take && last_popped) begin
                        state_nxt = ST_LOAD;
                    end
                end
                default: state_nxt = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ch_cnt      <= '0;
            pix_cnt     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            last_popped <= 1'b0;
        end else begin
            if (bias_pop || acc_pop) begin
                ch_cnt <= ch_wrap ? '0 : ch_cnt + 1'b1;
            end
            if (acc_pop && ch_wrap) begin
                pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
            end
            if (acc_pop) begin
                out_data  <= res;
                out_valid <= 1'b1;
            end else if (out_take) begin
                out_valid <= 1'b0;
            end
            if (acc_pop && frame_end) begin
                last_popped <= 1'b1;
            end else if (out_take && last_popped) begin
                last_popped <= 1'b0;
            end
        end
    end

    // The bank is always fully reloaded before RUN, so it carries no reset.
    always_ff @(posedge ap_clk) begin
        if (bias_pop) begin
            bank[ch_cnt] <= bias_V_dout;
        end
    end

    bias_sat_shift #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_bias_sat_shift (
        .acc  (acc_V_dout),
        .bias (bank[ch_cnt]),
        .res  (res)
    );

    assign bias_V_read    = bias_pop;
    assign acc_V_read     = acc_pop;
    assign output_V_write = out_valid;
    assign output_V_din   = out_data;
    assign dbg_state      = state;

endmodule

// File: tb/tb_bias_accum_7.sv
// Self-checking bench for bias_accum_7: FIFO source/sink models, a count-based
// reference of the frame protocol and an arithmetic reference of the datapath.
`timescale 1ns/1ps
module tb_bias_accum_7;
    import bias_accum_7_pkg::*;

    localparam int N_CH  = 2;
    localparam int N_PIX = 2;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int SHIFT = 8;
    localparam int TOTAL = N_CH * N_PIX;

    // ---------------- clock / reset ----------------
    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [OUT_W-1:0] bias_V_dout     = '0;
    logic             bias_V_empty_n  = 1'b0;
    logic             bias_V_read;
    logic [ACC_W-1:0] acc_V_dout      = '0;
    logic             acc_V_empty_n   = 1'b0;
    logic             acc_V_read;
    logic [OUT_W-1:0] output_V_din;
    logic             output_V_full_n = 1'b1;
    logic             output_V_write;
    state_e           dbg_state;

    bias_accum_7 #(
        .N_CH (N_CH), .N_PIX (N_PIX), .ACC_W (ACC_W), .OUT_W (OUT_W), .SHIFT (SHIFT)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .bias_V_dout     (bias_V_dout),
        .bias_V_empty_n  (bias_V_empty_n),
        .bias_V_read     (bias_V_read),
        .acc_V_dout      (acc_V_dout),
        .acc_V_empty_n   (acc_V_empty_n),
        .acc_V_read      (acc_V_read),
        .output_V_din    (output_V_din),
        .output_V_full_n (output_V_full_n),
        .output_V_write  (output_V_write),
        .dbg_state       (dbg_state)
    );

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_errs   = 0;

    logic [OUT_W-1:0] bias_src[$];
    logic [ACC_W-1:0] acc_src[$];
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] out_log[$];
    logic [OUT_W-1:0] bank_m [N_CH];

    int bias_cnt = 0, acc_cnt = 0, out_cnt = 0, frames_done = 0;
    int bias_pct = 100, acc_pct = 100, full_pct = 100;
    int stall_left = 0, stall_seen = 0, gap_cnt = 0;
    bit cont_mode = 1'b0;
    bit prev_wait = 1'b0;
    logic [OUT_W-1:0] prev_din = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Datapath reference in plain integer arithmetic.
    function automatic logic [OUT_W-1:0] ref_out(input logic [ACC_W-1:0] acc,
                                                 input logic [OUT_W-1:0] bias);
        longint s, r, hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        s  = longint'($signed(acc)) + longint'($signed(bias)) * (longint'(1) << SHIFT);
        r  = s >>> SHIFT;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`ifdef BIAS_ACCUM_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[OUT_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] rnd_acc();
        case ($urandom_range(3))
            0:       return ACC_W'($urandom);
            1:       return ACC_W'(int'($urandom_range(0, 4095)) - 2048);
            2:       return 32'h7FFF_FFFF;
            default: return 32'h8000_0000;
        endcase
    endfunction

    task automatic push_frame();
        for (int i = 0; i < N_CH; i++) bias_src.push_back(OUT_W'($urandom));
        for (int i = 0; i < TOTAL; i++) acc_src.push_back(rnd_acc());
    endtask

    task automatic clear_model();
        bias_src.delete(); acc_src.delete(); exp_q.delete();
        bias_cnt = 0; acc_cnt = 0; out_cnt = 0; prev_wait = 1'b0;
    endtask

    // ---------------- driver: one clock cycle with checks ----------------
    task automatic tick();
        bit loading, pend;
        logic [ACC_W-1:0] a;
        @(negedge ap_clk);
        bias_V_empty_n  = (bias_src.size() > 0) && ($urandom_range(99) < bias_pct);
        bias_V_dout     = (bias_src.size() > 0) ? bias_src[0] : OUT_W'($urandom);
        acc_V_empty_n   = (acc_src.size() > 0) && ($urandom_range(99) < acc_pct);
        acc_V_dout      = (acc_src.size() > 0) ? acc_src[0] : ACC_W'($urandom);
        if (stall_left > 0) begin
            output_V_full_n = 1'b0;
            stall_left--;
        end else begin
            output_V_full_n = ($urandom_range(99) < full_pct);
        end
        #1;
        loading = (bias_cnt < N_CH);
        pend    = (acc_cnt > out_cnt);
        check("bias_read", bias_V_read, loading && bias_V_empty_n);
        check("acc_read", acc_V_read,
              !loading && (acc_cnt < TOTAL) && acc_V_empty_n && (!pend || output_V_full_n));
        check("out_write", output_V_write, pend);
        check("state", dbg_state, loading ? ST_LOAD : ST_RUN);
        if (prev_wait) check("hold_din", output_V_din, prev_din);
        if (output_V_write && !output_V_full_n) stall_seen++;
        if (cont_mode && !loading && acc_cnt > 0 && out_cnt < TOTAL && !output_V_write)
            gap_cnt++;

        // scoreboard: accepted output against the oldest expected value
        if (output_V_write && output_V_full_n) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) check("out_data", output_V_din, exp_q.pop_front());
            out_log.push_back(output_V_din);
            out_cnt++;
        end
        if (bias_V_read && bias_V_empty_n) begin
            bank_m[bias_cnt % N_CH] = bias_src.pop_front();
            bias_cnt++;
        end
        if (acc_V_read && acc_V_empty_n) begin
            a = acc_src.pop_front();
            exp_q.push_back(ref_out(a, bank_m[acc_cnt % N_CH]));
            acc_cnt++;
        end
        if (out_cnt == TOTAL) begin
            bias_cnt = 0; acc_cnt = 0; out_cnt = 0;
            frames_done++;
        end
        prev_wait = output_V_write && !output_V_full_n;
        prev_din  = output_V_din;
    endtask

    task automatic run_frames(input int n, input int max_cycles);
        int start;
        start = frames_done;
        for (int c = 0; c < max_cycles && frames_done < start + n; c++) tick();
        check("frames_done", frames_done - start, n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bias_read"}, bias_V_read, 0);
        check({tag, "_acc_read"}, acc_V_read, 0);
        check({tag, "_write"}, output_V_write, 0);
        check({tag, "_din"}, output_V_din, 0);
        check({tag, "_state"}, dbg_state, ST_LOAD);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [OUT_W-1:0] neg_exp;

        // reset state, with FIFOs claiming data to show the reads are held off
        bias_V_empty_n = 1'b1; acc_V_empty_n = 1'b1;
        repeat (2) @(negedge ap_clk);
        check_idle_outputs("reset");
        bias_V_empty_n = 1'b0; acc_V_empty_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // small frame; accumulators are queued before the biases arrive
        out_log.delete();
        acc_src = '{32'h100, 32'h100, 32'h200, 32'h200};
        bias_src = '{16'h0001, 16'hFFFF};
        run_frames(1, 100);
        check("small_cnt", out_log.size(), 4);
        if (out_log.size() == 4) begin
            check("small_o0", out_log[0], 2);
            check("small_o1", out_log[1], 0);
            check("small_o2", out_log[2], 3);
            check("small_o3", out_log[3], 1);
        end
        tick();

        // saturation at both rails
        out_log.delete();
        bias_src = '{16'h7FFF, 16'h8000};
        acc_src  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0};
        run_frames(1, 100);
`ifdef BIAS_ACCUM_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'h8000;
`endif
        check("sat_cnt", out_log.size(), 4);
        if (out_log.size() == 4) begin
            check("sat_pos", out_log[0], 16'h7FFF);
            check("sat_neg", out_log[1], neg_exp);
        end

        // downstream stall of 5 cycles in mid-frame
        push_frame();
        for (int c = 0; c < 50 && acc_cnt == 0; c++) tick();
        stall_seen = 0;
        stall_left = 5;
        run_frames(1, 100);
        check("stall_cycles", stall_seen, 5);

        // two back-to-back frames with always-ready FIFOs
        push_frame(); push_frame();
        gap_cnt = 0; cont_mode = 1'b1;
        run_frames(2, 100);
        cont_mode = 1'b0;
        check("run_gaps", gap_cnt, 0);

        // asynchronous reset in the middle of a frame
        push_frame();
        for (int c = 0; c < 50 && acc_cnt < 2; c++) tick();
        @(negedge ap_clk);
        #2;
        bias_V_empty_n = 1'b1; acc_V_empty_n = 1'b1; output_V_full_n = 1'b1;
        ap_rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        bias_V_empty_n = 1'b0; acc_V_empty_n = 1'b0;
        clear_model();
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        acc_src.push_back(rnd_acc());
        for (int i = 1; i < TOTAL; i++) acc_src.push_back(rnd_acc());
        for (int i = 0; i < N_CH; i++) bias_src.push_back(OUT_W'($urandom));
        run_frames(1, 100);

        // randomized availability and data over many frames
        for (int f = 0; f < 24; f++) begin
            bias_pct = $urandom_range(30, 100);
            acc_pct  = $urandom_range(30, 100);
            full_pct = $urandom_range(30, 100);
            push_frame();
            run_frames(1, 2000);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/bias_accum_7.md
BIAS_ACCUM_7 -- requirements
Module: bias_accum_7

Interface
REQ-001 SHALL have parameter N_CH, default 16, output channels per pixel (bias words per frame).
REQ-002 SHALL have parameter N_PIX, default 64, pixels per frame.
REQ-003 SHALL have parameter ACC_W, default 32, accumulator input width.
REQ-004 SHALL have parameter OUT_W, default 16, output width (equals coeff_width).
REQ-005 SHALL have parameter SHIFT, default 8, fixed-point fraction bits removed at output.
REQ-006 SHALL have port ap_clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port bias_V_dout  in  OUT_W  signed bias word from the bias_7 FIFO.
REQ-009 SHALL have port bias_V_empty_n  in  1  bias FIFO holds data.
REQ-010 SHALL have port bias_V_read  out  1  pops one bias word.
REQ-011 SHALL have port acc_V_dout  in  ACC_W  signed convolution accumulator.
REQ-012 SHALL have port acc_V_empty_n  in  1  accumulator FIFO holds data.
REQ-013 SHALL have port acc_V_read  out  1  pops one accumulator.
REQ-014 SHALL have port output_V_din  out  OUT_W  biased, scaled, saturated result.
REQ-015 SHALL have port output_V_full_n  in  1  downstream FIFO can accept.
REQ-016 SHALL have port output_V_write  out  1  pushes output_V_din.

Function
REQ-017 SHALL implement FSM LOAD -> RUN -> LOAD; RUN is entered after N_CH bias pops and LOAD is re-entered after the N_CH*N_PIX-th output is accepted.
REQ-018 LOAD: SHALL assert bias_V_read exactly when bias_V_empty_n=1 and store the word in bank[ch_cnt], with ch_cnt incrementing 0..N_CH-1; acc_V_read SHALL be 0.
REQ-019 RUN: SHALL assert acc_V_read when acc_V_empty_n=1 and the output register is empty or being drained this cycle (output_V_write and output_V_full_n); bias_V_read SHALL be 0.
REQ-020 The accumulator popped at channel index c SHALL use bank[c]; c wraps N_CH-1 -> 0 and increments the pixel counter; pixel counter wraps N_PIX-1 -> 0 at frame end.
REQ-021 Arithmetic: sum = acc + (sign_extend(bias) << SHIFT), computed at ACC_W+1 bits without overflow; res = sum >>> SHIFT (arithmetic); saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 Latency: the result SHALL appear on output_V_din with output_V_write=1 on the cycle after the acc pop.
REQ-023 output_V_write SHALL stay 1 and output_V_din stable until output_V_full_n=1 is sampled; no output is dropped or duplicated.
REQ-024 Back-to-back: with full_n=1 and empty_n=1 continuously, throughput SHALL be one output per cycle.
REQ-025 The FSM SHALL switch RUN -> LOAD only when the last output of the frame is accepted; a pending last pop SHALL NOT be lost.
REQ-026 bias_V_empty_n and acc_V_empty_n SHALL be ignored outside their own state.

Reset
REQ-027 On ap_rst_n=0 (asynchronous, any cycle, including mid-frame): state=LOAD, counters=0, output register empty, bias_V_read=0, acc_V_read=0, output_V_write=0, output_V_din=0.
REQ-028 The bias bank SHALL NOT require reset; after reset it is reloaded before any use.

Configuration
REQ-029 Macro BIAS_ACCUM_RELU_EN defined: res SHALL be clamped to >= 0 after saturation (fused ReLU).
REQ-030 Macro undefined: signed saturated res SHALL be output unchanged.

Structure
REQ-031 N_CH/N_PIX defaults SHALL derive from kern_s_k_7 and the layer-7 output size constants in the shared layers_sizes header; OUT_W from coeff_width; the ACC_W and SHIFT constants SHALL be added to my_types.
REQ-032 The shift/saturate/ReLU datapath SHALL be a combinational sub-module bias_sat_shift.

Verification
REQ-033 N_CH=2, N_PIX=2, biases {1,-1}, acc {0x100,0x100,0x200,0x200} -> outputs {2,0,3,1}, then FSM returns to LOAD.
REQ-034 acc=0x7FFFFFFF, bias=0x7FFF -> output 0x7FFF; acc=0x80000000, bias=0x8000 -> 0x8000 (0x0000 with BIAS_ACCUM_RELU_EN).
REQ-035 output_V_full_n held 0 for 5 cycles during a frame -> output_V_write stays 1 and output_V_din stays stable, acc_V_read=0, no loss after release.
REQ-036 acc FIFO presented during LOAD -> acc_V_read=0 until all N_CH biases are popped.
REQ-037 ap_rst_n pulsed low mid-frame -> all outputs 0 immediately, next activity is bias_V_read.
REQ-038 Continuous FIFOs for two frames -> one output per cycle in RUN, exactly N_CH*N_PIX outputs per frame.
